mem_ctrl: RTL

- Sits between the CPU's IF/MEM stages and the shared byte-wide memory/IO bus.
- Serialises word, halfword and byte accesses into little-endian single-byte bus transactions.
- Arbitrates between instruction fetch (IF) and data access (MEM); MEM has priority.
- Returns assembled read data and a one-cycle done pulse to the winning requester.

---
 rtl/mem_ctrl_if.sv | 54 +++++
 rtl/mem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: groups the CPU request/response signals and the byte-wide
// memory/IO bus of mem_ctrl. The controller uses the master modport; the
// CPU stages and memory model use the slave modport.
// Optional macro MEM_CTRL_ALIGN_CHECK_EN adds the misalign_o signal.
interface mem_ctrl_if;
   logic        rdy_in;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [1:0]  dm_size_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_done_o;
   logic [31:0] dm_rdata_o;
   logic        busy_o;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
   logic        misalign_o;
`endif

   modport master (
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      output misalign_o,
`endif
      input  rdy_in,
      input  if_req_i, if_addr_i,
      output if_done_o, if_data_o,
      input  dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
      output dm_done_o, dm_rdata_o,
      output busy_o,
      input  mem_din,
      output mem_dout, mem_a, mem_wr
   );

   modport slave (
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      input  misalign_o,
`endif
      output rdy_in,
      output if_req_i, if_addr_i,
      input  if_done_o, if_data_o,
      output dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
      input  dm_done_o, dm_rdata_o,
      input  busy_o,
      output mem_din,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests (MEM first) and serialises each
// access into little-endian single-byte bus cycles. Reads are pipelined with
// READ_LAT cycles of bus latency; rdy_in low freezes everything and discards
// bytes in flight, which are reissued on resume.
// Optional macro MEM_CTRL_ALIGN_CHECK_EN: misaligned half/word accesses skip
// the bus, complete with zero data and raise misalign_o for the DONE cycle.
module mem_ctrl #(
   parameter int READ_LAT = 2
) (
   input  logic       clk_in,
   input  logic       rst_in,
   mem_ctrl_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   logic [1:0]  state;
   logic        owner;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] rbuf;
   logic [31:0] a_hold;
   logic [31:0] if_data;
   logic [31:0] dm_rdata;
   logic [2:0]  n;
   logic [2:0]  i;
   logic [2:0]  j;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
   logic        misalign;
`endif

   logic        rdy;
   logic        grant_dm;
   logic        grant_if;
   logic [31:0] g_addr;
   logic [2:0]  g_n;
   logic        rd_issue;
   logic        wr_issue;
   logic        capture;
   logic        done_pulse;
   logic [31:0] cur_a;
   logic [31:0] rbuf_next;

   // Byte count of a MEM access; size 11 behaves as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

`ifdef MEM_CTRL_ALIGN_CHECK_EN
   // Halfwords must be even, words must be 4-byte aligned.
   function automatic logic is_misaligned(input logic [2:0] nb, input logic [1:0] a);
      return ((nb == 3'd2) && a[0]) || ((nb == 3'd4) && (a != 2'b00));
   endfunction
`endif

   assign rdy = bus.rdy_in;

   // Arbitration in IDLE: MEM wins over IF.
   always_comb begin
      grant_dm = (state == IDLE) && bus.dm_req_i;
      grant_if = (state == IDLE) && !bus.dm_req_i && bus.if_req_i;
      g_addr   = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
      g_n      = grant_dm ? size_bytes(bus.dm_size_i) : 3'd4;
   end

   // Bus issue qualifiers and the next assembled read buffer.
   always_comb begin
      rd_issue   = rdy && (state == RD) && (i < n);
      wr_issue   = rdy && (state == WR);
      cur_a      = base + {29'd0, i};
      done_pulse = rdy && (state == DONE);
      rbuf_next  = rbuf;
      rbuf_next[{j[1:0], 3'b000} +: 8] = bus.mem_din;
   end

   generate
      if (READ_LAT <= 1) begin : g_lat1
         assign capture = rd_issue;
      end else begin : g_latn
         logic [READ_LAT-2:0] flight;

         // Tracks issued read bytes until their data is due; a pause drops them.
         always_ff @(posedge clk_in) begin
            if (!rst_in || !rdy || (state != RD)) begin
               flight <= '0;
            end else begin
               flight[0] <= rd_issue;
               for (int k = 1; k < READ_LAT - 1; k++) begin
                  flight[k] <= flight[k-1];
               end
            end
         end

         assign capture = rdy && (state == RD) && flight[READ_LAT-2];
      end
   endgenerate

   // Main FSM, counters and data registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         base     <= '0;
         wdata    <= '0;
         rbuf     <= '0;
         a_hold   <= '0;
         if_data  <= '0;
         dm_rdata <= '0;
         n        <= '0;
         i        <= '0;
         j        <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
         misalign <= 1'b0;
`endif
      end else if (!rdy) begin
         // Unreceived bytes are reissued after the pause.
         if (state == RD) begin
            i <= j;
         end
      end else begin
         case (state)
            IDLE: begin
               if (grant_dm || grant_if) begin
                  base  <= g_addr;
                  n     <= g_n;
                  wdata <= bus.dm_wdata_i;
                  owner <= grant_dm ? OWN_DM : OWN_IF;
                  i     <= '0;
                  j     <= '0;
                  rbuf  <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                  if (is_misaligned(g_n, g_addr[1:0])) begin
                     state    <= DONE;
                     misalign <= 1'b1;
                     if (grant_dm) begin
                        dm_rdata <= '0;
                     end else begin
                        if_data <= '0;
                     end
                  end else
`endif
                  if (grant_dm && bus.dm_we_i) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (rd_issue) begin
                  i      <= i + 3'd1;
                  a_hold <= cur_a;
               end
               if (capture) begin
                  j    <= j + 3'd1;
                  rbuf <= rbuf_next;
                  if (j == n - 3'd1) begin
                     state <= DONE;
                     if (owner == OWN_DM) begin
                        dm_rdata <= rbuf_next;
                     end else begin
                        if_data <= rbuf_next;
                     end
                  end
               end
            end
            WR: begin
               i      <= i + 3'd1;
               a_hold <= cur_a;
               if (i == n - 3'd1) begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
               misalign <= 1'b0;
`endif
            end
         endcase
      end
   end

   // Output drive: bus address follows the issue counter, else holds.
   always_comb begin
      bus.mem_a      = (rd_issue || wr_issue) ? cur_a : a_hold;
      bus.mem_wr     = wr_issue;
      bus.mem_dout   = (state == WR) ? wdata[{i[1:0], 3'b000} +: 8] : 8'h00;
      bus.if_done_o  = done_pulse && (owner == OWN_IF);
      bus.dm_done_o  = done_pulse && (owner == OWN_DM);
      bus.if_data_o  = if_data;
      bus.dm_rdata_o = dm_rdata;
      bus.busy_o     = (state != IDLE);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      bus.misalign_o = (state == DONE) && misalign;
`endif
   end

endmodule
